// File: rtl/lab2_sub_pkg.sv
// ============================================================================
// Module  : lab2_sub_pkg
// Purpose : Shared definitions for the lab2 serial subtractor: FSM state
//           encoding and helpers that size the chunk counter from N and W.
// Ports   : none (package)
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

package lab2_sub_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    DONE = 2'd2
  } state_e;

  // Number of W-bit chunks in an N-bit operand (CHUNKS = N/W).
  function automatic int calc_chunks(input int n, input int w);
    return n / w;
  endfunction

  // Chunk-index width: $clog2(CHUNKS), never less than one bit.
  function automatic int calc_idx_w(input int chunks);
    return (chunks > 1) ? $clog2(chunks) : 1;
  endfunction

endpackage

`default_nettype wire

// File: rtl/serial_subtractor_fullsub.sv
// ============================================================================
// Module  : FullSubtractor
// Purpose : One-bit full subtractor, the bitwise counterpart of FullAdder.
//           diff = a - b - bin (mod 2), bout = 1 when the subtraction borrows.
// Ports   : a, b    - operand bits
//           bin     - borrow in from the less significant bit
//           diff    - difference bit
//           bout    - borrow out to the more significant bit
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module FullSubtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  assign diff = a ^ b ^ bin;
  // Borrow when b exceeds a, or when they are equal and a borrow is pending.
  assign bout = (~a & b) | (~(a ^ b) & bin);

endmodule

`default_nettype wire

// File: rtl/serial_subtractor.sv
// ============================================================================
// Module  : serial_subtractor
// Purpose : Multi-cycle unsigned subtractor computing d = a - b over N bits,
//           W bits per clock, LSB chunk first, with a registered borrow
//           between chunks. d[N] holds the final borrow (1 iff a < b).
// Params  : N - operand width (multiple of W), W - bits per cycle (1..N)
// Ports   : clk, rst (async, active high)
//           start/ready     - operand handshake, a/b sampled on accept
//           valid/out_ready - result handshake, d meaningful while valid
//           bi              - borrow in (only with SERIAL_SUB_BORROW_IN_EN)
// Config  : `define SERIAL_SUB_BORROW_IN_EN adds bi; result is a - b - bi.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module serial_subtractor
  import lab2_sub_pkg::*;
#(
  parameter int N = 32,
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         start,
  output logic         ready,
  input  logic [N-1:0] a,
  input  logic [N-1:0] b,
`ifdef SERIAL_SUB_BORROW_IN_EN
  input  logic         bi,
`endif
  output logic         valid,
  input  logic         out_ready,
  output logic [N:0]   d
);

  localparam int CHUNKS = calc_chunks(N, W);
  localparam int IDX_W  = calc_idx_w(CHUNKS);
  localparam int TBL    = 1 << IDX_W;
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(CHUNKS - 1);

  state_e             state_q, state_d;
  logic [N-1:0]       a_q, a_d;
  logic [N-1:0]       b_q, b_d;
  logic [IDX_W-1:0]   idx_q, idx_d;
  logic               borrow_q, borrow_d;
  logic [N:0]         d_q, d_d;

  logic               accept;
  logic               borrow_init;
  logic [W-1:0]       a_chunk, b_chunk, diff;
  logic [W:0]         bchain;

`ifdef SERIAL_SUB_BORROW_IN_EN
  assign borrow_init = bi;
`else
  assign borrow_init = 1'b0;
`endif

  // --------------------------------------------------------------------------
  // Chunk mux. Tables are padded to a power of two so every index value
  // selects a defined entry.
  // --------------------------------------------------------------------------
  logic [W-1:0] a_tbl [TBL];
  logic [W-1:0] b_tbl [TBL];

  for (genvar k = 0; k < TBL; k++) begin : g_chunk
    if (k < CHUNKS) begin : g_live
      assign a_tbl[k] = a_q[k*W +: W];
      assign b_tbl[k] = b_q[k*W +: W];
    end else begin : g_pad
      assign a_tbl[k] = '0;
      assign b_tbl[k] = '0;
    end
  end

  assign a_chunk = a_tbl[idx_q];
  assign b_chunk = b_tbl[idx_q];

  // --------------------------------------------------------------------------
  // W-bit ripple subtract of one chunk, seeded by the registered borrow.
  // --------------------------------------------------------------------------
  assign bchain[0] = borrow_q;

  for (genvar i = 0; i < W; i++) begin : g_bit
    FullSubtractor u_fs (
      .a    (a_chunk[i]),
      .b    (b_chunk[i]),
      .bin  (bchain[i]),
      .diff (diff[i]),
      .bout (bchain[i+1])
    );
  end

  // --------------------------------------------------------------------------
  // FSM: state register
  // --------------------------------------------------------------------------
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    if (start)              state_d = BUSY;
      BUSY:    if (idx_q == LAST_IDX)  state_d = DONE;
      DONE:    if (out_ready)          state_d = IDLE;
      default:                         state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    ready = (state_q == IDLE);
    valid = (state_q == DONE);
  end

  assign accept = start && ready;

  // --------------------------------------------------------------------------
  // Datapath next-state
  // --------------------------------------------------------------------------
  always_comb begin
    a_d      = a_q;
    b_d      = b_q;
    idx_d    = idx_q;
    borrow_d = borrow_q;
    d_d      = d_q;
    if (accept) begin
      a_d      = a;
      b_d      = b;
      idx_d    = '0;
      borrow_d = borrow_init;
    end else if (state_q == BUSY) begin
      for (int k = 0; k < CHUNKS; k++) begin
        if (idx_q == IDX_W'(k)) begin
          d_d[k*W +: W] = diff;
        end
      end
      borrow_d = bchain[W];
      if (idx_q == LAST_IDX) begin
        d_d[N] = bchain[W];
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      a_q      <= '0;
      b_q      <= '0;
      idx_q    <= '0;
      borrow_q <= 1'b0;
      d_q      <= '0;
    end else begin
      a_q      <= a_d;
      b_q      <= b_d;
      idx_q    <= idx_d;
      borrow_q <= borrow_d;
      d_q      <= d_d;
    end
  end

  assign d = d_q;

endmodule

`default_nettype wire

// File: tb/tb_serial_subtractor.sv
// ============================================================================
// Module  : tb_serial_subtractor
// Purpose : Self-checking bench for serial_subtractor (N=32, W=8). Directed
//           corner cases plus randomized operations against an arithmetic
//           reference model; covers reset, latency, backpressure, ignored
//           start requests and reset in the middle of an operation.
// Rev     : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_serial_subtractor;

  localparam int N      = 32;
  localparam int W      = 8;
  localparam int CHUNKS = N / W;
`ifdef SERIAL_SUB_BORROW_IN_EN
  localparam bit HAS_BI = 1'b1;
`else
  localparam bit HAS_BI = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst;
  logic         start;
  logic         ready;
  logic [N-1:0] a;
  logic [N-1:0] b;
  logic         bi;
  logic         valid;
  logic         out_ready;
  logic [N:0]   d;

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  serial_subtractor #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst       (rst),
    .start     (start),
    .ready     (ready),
    .a         (a),
    .b         (b),
`ifdef SERIAL_SUB_BORROW_IN_EN
    .bi        (bi),
`endif
    .valid     (valid),
    .out_ready (out_ready),
    .d         (d)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, got, exp);
    end
  endtask

  // Reference: N+1-bit two's-complement difference; the top bit is the borrow.
  function automatic logic [N:0] ref_sub(input logic [N-1:0] x, input logic [N-1:0] y,
                                         input logic bin);
    logic [N:0] r;
    r = {1'b0, x} - {1'b0, y} - {{N{1'b0}}, bin};
    return r;
  endfunction

  task automatic run_op(input logic [N-1:0] ta, input logic [N-1:0] tb,
                        input logic tbi, input int hold);
    logic [N:0] exp;
    int         cyc;
    exp = ref_sub(ta, tb, HAS_BI ? tbi : 1'b0);
    @(negedge clk);
    check("ready_idle", {63'd0, ready}, 64'd1);
    a         = ta;
    b         = tb;
    bi        = tbi;
    start     = 1'b1;
    out_ready = (hold == 0);
    @(posedge clk); #1;
    check("ready_after_accept", {63'd0, ready}, 64'd0);
    cyc = 0;
    // Garbage operands and random start pulses while BUSY must be ignored.
    while (!valid && cyc < 64) begin
      start = 1'($urandom_range(0, 1));
      a     = $urandom;
      b     = $urandom;
      bi    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      cyc++;
      if (!valid) check("ready_busy", {63'd0, ready}, 64'd0);
    end
    start = 1'b0;
    check("latency", 64'(cyc), 64'(CHUNKS));
    check("valid_done", {63'd0, valid}, 64'd1);
    check("d_result", 64'(d), 64'(exp));
    for (int i = 0; i < hold; i++) begin
      start = 1'($urandom_range(0, 1));
      a     = $urandom;
      b     = $urandom;
      @(posedge clk); #1;
      check("valid_hold", {63'd0, valid}, 64'd1);
      check("d_hold", 64'(d), 64'(exp));
      check("ready_hold", {63'd0, ready}, 64'd0);
    end
    start     = 1'b0;
    out_ready = 1'b1;
    @(posedge clk); #1;
    check("valid_after_hs", {63'd0, valid}, 64'd0);
    check("ready_after_hs", {63'd0, ready}, 64'd1);
    check("d_after_hs", 64'(d), 64'(exp));
    out_ready = 1'b0;
  endtask

  initial begin
    rst       = 1'b0;
    start     = 1'b0;
    a         = '0;
    b         = '0;
    bi        = 1'b0;
    out_ready = 1'b0;

    // Asynchronous reset before any clock edge.
    #2 rst = 1'b1;
    #1;
    check("rst_ready", {63'd0, ready}, 64'd1);
    check("rst_valid", {63'd0, valid}, 64'd0);
    check("rst_d", 64'(d), 64'd0);
    @(negedge clk);
    rst = 1'b0;

    // Directed cases.
    run_op(32'd10, 32'd3, 1'b0, 0);
    run_op(32'd3, 32'd10, 1'b0, 0);
    run_op(32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0, 0);
    run_op(32'h0000_0100, 32'd1, 1'b0, 0);
    run_op(32'd0, 32'd1, 1'b0, 0);
    run_op(32'h1234_5678, 32'h0876_9ABC, 1'b0, 6);

    // Reset after the second BUSY edge, with partial result already in d.
    @(negedge clk);
    a         = 32'hFFFF_FFFF;
    b         = 32'd0;
    bi        = 1'b0;
    start     = 1'b1;
    out_ready = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    @(posedge clk);
    @(posedge clk); #3;
    rst = 1'b1;
    #1;
    check("midrst_ready", {63'd0, ready}, 64'd1);
    check("midrst_valid", {63'd0, valid}, 64'd0);
    check("midrst_d", 64'(d), 64'd0);
    @(negedge clk);
    rst       = 1'b0;
    out_ready = 1'b0;
    run_op(32'd5, 32'd2, 1'b0, 0);

    if (HAS_BI) run_op(32'd5, 32'd5, 1'b1, 0);

    // Randomized operations with random backpressure.
    for (int t = 0; t < 20; t++) begin
      run_op($urandom, (t % 4 == 0) ? 32'($urandom_range(0, 255)) : $urandom,
             1'($urandom_range(0, 1)), $urandom_range(0, 3));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
